// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Single-outstanding instruction fetch unit. Issues one memory
//            request per instruction, holds the returned word in an output
//            slot for decode, and handles redirects (jumps) by discarding any
//            in-flight response. A saturating wait counter raises a sticky
//            timeout flag if memory stops responding.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            pc_i, jump_en_i    - current PC and redirect/flush from PC logic
//            pc_adv_o           - pulse: PC register may advance by 4
//            imem_*             - request strobe/address, response valid/data
//            inst_valid_o, inst_o, inst_pc_o, id_ready_i - decode slot
//            fetch_err_o        - sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        jump_en_i,
   output logic        pc_adv_o,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   input  logic        id_ready_i,
   output logic        fetch_err_o
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t           state;
   logic [31:0]      req_pc;
   logic [CNT_W-1:0] wait_cnt;

   logic             issue;
   logic             load;
   logic [CNT_W-1:0] cnt_inc;

   // Request and PC-advance are decided in the same cycle they are
   // presented, so a 1-cycle memory sustains one instruction every two
   // cycles. Both are forced low while reset is asserted.
   always_comb begin
      issue   = !rst && (state == IDLE) && !jump_en_i &&
                (!inst_valid_o || id_ready_i);
      load    = !rst && (state == WAIT) && imem_rvalid_i && !jump_en_i;
      cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
   end

   assign imem_req_o  = issue;
   assign imem_addr_o = issue ? pc_i : 32'h0;
   assign pc_adv_o    = load;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         req_pc       <= 32'h0;
         wait_cnt     <= '0;
         inst_valid_o <= 1'b0;
         inst_o       <= 32'h0;
         inst_pc_o    <= 32'h0;
         fetch_err_o  <= 1'b0;
      end else begin
         // Output slot: a redirect flushes it, even against a consume;
         // a fresh load beats a consume at the same edge.
         if (jump_en_i) begin
            inst_valid_o <= 1'b0;
         end else if (load) begin
            inst_valid_o <= 1'b1;
            inst_o       <= imem_rdata_i;
            inst_pc_o    <= req_pc;
         end else if (inst_valid_o && id_ready_i) begin
            inst_valid_o <= 1'b0;
         end

         // Sticky flag: set on the edge where the counter reaches TIMEOUT.
         if ((state == WAIT || state == DROP) && (cnt_inc == CNT_MAX)) begin
            fetch_err_o <= 1'b1;
         end

         case (state)
            IDLE: begin
               // Responses arriving here are stale and deliberately ignored.
               if (issue) begin
                  state    <= WAIT;
                  req_pc   <= pc_i;
                  wait_cnt <= '0;
               end
            end
            WAIT: begin
               if (imem_rvalid_i) begin
                  state <= IDLE;
               end else if (jump_en_i) begin
                  // Request still in flight: its response must be swallowed.
                  state    <= DROP;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= cnt_inc;
               end
            end
            DROP: begin
               if (imem_rvalid_i) begin
                  state <= IDLE;
               end else begin
                  wait_cnt <= cnt_inc;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Self-checking bench for inst_fetch. A table of per-cycle input
//            and expected-output records covers fetch, stall, redirects and
//            simultaneous events; hand-written sequences cover timeout,
//            reset mid-request and stale responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic [31:0] pc_i;
   logic        jump_en_i;
   logic        pc_adv_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        id_ready_i;
   logic        fetch_err_o;

   int n_pass  = 0;
   int n_total = 0;

   inst_fetch #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .jump_en_i    (jump_en_i),
      .pc_adv_o     (pc_adv_o),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i (imem_rdata_i),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o),
      .id_ready_i   (id_ready_i),
      .fetch_err_o  (fetch_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic        jmp;
      logic        rv;
      logic [31:0] rdata;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        adv;
      logic        valid;
      logic [31:0] inst;
      logic [31:0] ipc;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [31:0] pc, input logic j,
                      input logic rv, input logic [31:0] rd, input logic rdy,
                      input logic req, input logic [31:0] addr, input logic adv,
                      input logic valid, input logic [31:0] inst,
                      input logic [31:0] ipc, input logic err);
      vec_t v;
      v.rst = r; v.pc = pc; v.jmp = j; v.rv = rv; v.rdata = rd; v.rdy = rdy;
      v.req = req; v.addr = addr; v.adv = adv; v.valid = valid;
      v.inst = inst; v.ipc = ipc; v.err = err;
      vecs.push_back(v);
   endtask

   // Apply inputs just after a rising edge, then wait to mid-cycle to sample.
   task automatic drive(input logic r, input logic [31:0] pc, input logic j,
                        input logic rv, input logic [31:0] rd, input logic rdy);
      @(posedge clk);
      #1;
      rst = r; pc_i = pc; jump_en_i = j;
      imem_rvalid_i = rv; imem_rdata_i = rd; id_ready_i = rdy;
      #3;
   endtask

   task automatic check_all(input string name, input logic req,
                            input logic [31:0] addr, input logic adv,
                            input logic valid, input logic [31:0] inst,
                            input logic [31:0] ipc, input logic err);
      n_total++;
      if ({imem_req_o, imem_addr_o, pc_adv_o, inst_valid_o, inst_o, inst_pc_o, fetch_err_o}
          !== {req, addr, adv, valid, inst, ipc, err}) begin
         $display("FAIL %s: got req=%0b addr=%h adv=%0b valid=%0b inst=%h pc=%h err=%0b | expected req=%0b addr=%h adv=%0b valid=%0b inst=%h pc=%h err=%0b",
                  name, imem_req_o, imem_addr_o, pc_adv_o, inst_valid_o, inst_o,
                  inst_pc_o, fetch_err_o, req, addr, adv, valid, inst, ipc, err);
      end else begin
         n_pass++;
      end
   endtask

   initial begin
      //   rst pc           j  rv rdata        rdy | req addr         adv val inst         ipc          err
      add(1, 32'h80000000, 0, 0, 32'h0,        1,   0, 32'h0,        0, 0, 32'h0,        32'h0,        0);
      add(0, 32'h80000000, 0, 0, 32'h0,        1,   1, 32'h80000000, 0, 0, 32'h0,        32'h0,        0);
      add(0, 32'h80000000, 0, 1, 32'h00000413, 1,   0, 32'h0,        1, 0, 32'h0,        32'h0,        0);
      add(0, 32'h80000004, 0, 0, 32'h0,        0,   0, 32'h0,        0, 1, 32'h00000413, 32'h80000000, 0);
      add(0, 32'h80000004, 0, 0, 32'h0,        0,   0, 32'h0,        0, 1, 32'h00000413, 32'h80000000, 0);
      add(0, 32'h80000004, 0, 1, 32'hdeadbeef, 0,   0, 32'h0,        0, 1, 32'h00000413, 32'h80000000, 0);
      add(0, 32'h80000004, 0, 0, 32'h0,        0,   0, 32'h0,        0, 1, 32'h00000413, 32'h80000000, 0);
      add(0, 32'h80000004, 0, 0, 32'h0,        0,   0, 32'h0,        0, 1, 32'h00000413, 32'h80000000, 0);
      add(0, 32'h80000004, 0, 0, 32'h0,        1,   1, 32'h80000004, 0, 1, 32'h00000413, 32'h80000000, 0);
      add(0, 32'h80000004, 1, 0, 32'h0,        1,   0, 32'h0,        0, 0, 32'h00000413, 32'h80000000, 0);
      add(0, 32'h80000100, 0, 0, 32'h0,        1,   0, 32'h0,        0, 0, 32'h00000413, 32'h80000000, 0);
      add(0, 32'h80000100, 0, 1, 32'h11111111, 1,   0, 32'h0,        0, 0, 32'h00000413, 32'h80000000, 0);
      add(0, 32'h80000100, 0, 0, 32'h0,        1,   1, 32'h80000100, 0, 0, 32'h00000413, 32'h80000000, 0);
      add(0, 32'h80000100, 0, 1, 32'h22222222, 1,   0, 32'h0,        1, 0, 32'h00000413, 32'h80000000, 0);
      add(0, 32'h80000104, 0, 0, 32'h0,        1,   1, 32'h80000104, 0, 1, 32'h22222222, 32'h80000100, 0);
      add(0, 32'h80000104, 1, 1, 32'h33333333, 1,   0, 32'h0,        0, 0, 32'h22222222, 32'h80000100, 0);
      add(0, 32'h80000200, 0, 0, 32'h0,        1,   1, 32'h80000200, 0, 0, 32'h22222222, 32'h80000100, 0);
      add(0, 32'h80000200, 0, 1, 32'h44444444, 1,   0, 32'h0,        1, 0, 32'h22222222, 32'h80000100, 0);
      add(0, 32'h80000204, 1, 0, 32'h0,        1,   0, 32'h0,        0, 1, 32'h44444444, 32'h80000200, 0);
      add(0, 32'h80000300, 0, 0, 32'h0,        0,   1, 32'h80000300, 0, 0, 32'h44444444, 32'h80000200, 0);
      add(0, 32'h80000300, 0, 1, 32'h55555555, 0,   0, 32'h0,        1, 0, 32'h44444444, 32'h80000200, 0);
      add(0, 32'h80000304, 0, 0, 32'h0,        0,   0, 32'h0,        0, 1, 32'h55555555, 32'h80000300, 0);

      rst = 1'b1; pc_i = 32'h80000000; jump_en_i = 1'b0;
      imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; id_ready_i = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].pc, vecs[i].jmp, vecs[i].rv, vecs[i].rdata, vecs[i].rdy);
         check_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].adv,
                   vecs[i].valid, vecs[i].inst, vecs[i].ipc, vecs[i].err);
      end

      // Timeout: no response; flag sets on the 4th WAIT edge and stays set.
      drive(0, 32'h80000400, 0, 0, 32'h0, 1);
      check_all("to_issue", 1, 32'h80000400, 0, 1, 32'h55555555, 32'h80000300, 0);
      for (int k = 1; k <= 4; k++) begin
         drive(0, 32'h80000400, 0, 0, 32'h0, 1);
         check_all($sformatf("to_wait%0d", k), 0, 32'h0, 0, 0, 32'h55555555, 32'h80000300, 0);
      end
      drive(0, 32'h80000400, 0, 0, 32'h0, 1);
      check_all("to_set", 0, 32'h0, 0, 0, 32'h55555555, 32'h80000300, 1);
      drive(0, 32'h80000400, 0, 0, 32'h0, 1);
      check_all("to_hold", 0, 32'h0, 0, 0, 32'h55555555, 32'h80000300, 1);
      drive(0, 32'h80000400, 0, 1, 32'h66666666, 1);
      check_all("to_late_adv", 0, 32'h0, 1, 0, 32'h55555555, 32'h80000300, 1);
      drive(0, 32'h80000404, 0, 0, 32'h0, 0);
      check_all("to_late_load", 0, 32'h0, 0, 1, 32'h66666666, 32'h80000400, 1);

      // Reset clears the flag; first request goes out in the first free cycle.
      drive(1, 32'h80000404, 0, 0, 32'h0, 0);
      check_all("rst_cycle", 0, 32'h0, 0, 1, 32'h66666666, 32'h80000400, 1);
      drive(0, 32'h80000500, 0, 0, 32'h0, 1);
      check_all("rst_first_req", 1, 32'h80000500, 0, 0, 32'h0, 32'h0, 0);

      // Reset while waiting, stale response arrives after the FSM is idle.
      drive(1, 32'h80000500, 0, 0, 32'h0, 1);
      check_all("rst_in_wait", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
      drive(1, 32'h80000500, 0, 1, 32'h77777777, 1);
      check_all("stale_resp", 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
      drive(0, 32'h80000600, 0, 0, 32'h0, 1);
      check_all("post_rst_req", 1, 32'h80000600, 0, 0, 32'h0, 32'h0, 0);
      drive(0, 32'h80000600, 0, 1, 32'h88888888, 1);
      check_all("post_rst_adv", 0, 32'h0, 1, 0, 32'h0, 32'h0, 0);
      drive(0, 32'h80000604, 0, 0, 32'h0, 0);
      check_all("post_rst_load", 0, 32'h0, 0, 1, 32'h88888888, 32'h80000600, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
